// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stage
// Brief   : Instruction fetch (PC, next-PC select) plus IF/ID pipeline register.
//           Optional stall/flush performance counters under IF_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        STALL,
    input  logic        Condep,
    input  logic [1:0]  Pcsrc,
    input  logic        jr,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    input  logic [31:0] Inst,
    output logic [31:0] Iaddr,
    output logic [31:0] dPC4,
    output logic [31:0] dInst,
    output logic        dValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc_raw;
    logic [31:0] npc;

    assign pc_plus4 = pc + 32'd4;
    assign Iaddr    = pc;

    // jr overrides Pcsrc; codes 00 and 01 both fall through to sequential fetch
    always_comb begin
        npc_raw = pc_plus4;
        if (jr) begin
            npc_raw = JrAddr;
        end else begin
            case (Pcsrc)
                2'b10:   npc_raw = BranchAddr;
                2'b11:   npc_raw = JumpAddr;
                default: npc_raw = pc_plus4;
            endcase
        end
    end

    assign npc = npc_raw & ALIGN_MASK;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            dPC4   <= 32'd0;
            dInst  <= NOP_INST;
            dValid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    pc     <= RESET_PC;
                    dPC4   <= 32'd0;
                    dInst  <= NOP_INST;
                    dValid <= 1'b0;
                    state  <= RUN;
                end
                RUN: begin
                    if (!Condep) begin
                        // flush wins over stall: the redirect must not be lost
                        pc     <= npc;
                        dPC4   <= 32'd0;
                        dInst  <= NOP_INST;
                        dValid <= 1'b0;
                    end else if (STALL) begin
                        pc     <= npc;
                        dPC4   <= pc_plus4;
                        dInst  <= Inst;
                        dValid <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            StallCnt <= 32'd0;
            FlushCnt <= 32'd0;
        end else if (state == RUN) begin
            if (!Condep) begin
                FlushCnt <= FlushCnt + 32'd1;
            end else if (!STALL) begin
                StallCnt <= StallCnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_stage
// Brief   : Directed self-checking bench for if_id_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        Clk;
    logic        Clrn;
    logic        STALL;
    logic        Condep;
    logic [1:0]  Pcsrc;
    logic        jr;
    logic [31:0] BranchAddr;
    logic [31:0] JumpAddr;
    logic [31:0] JrAddr;
    logic [31:0] Inst;
    logic [31:0] Iaddr;
    logic [31:0] dPC4;
    logic [31:0] dInst;
    logic        dValid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] FlushCnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .Clk        (Clk),
        .Clrn       (Clrn),
        .STALL      (STALL),
        .Condep     (Condep),
        .Pcsrc      (Pcsrc),
        .jr         (jr),
        .BranchAddr (BranchAddr),
        .JumpAddr   (JumpAddr),
        .JrAddr     (JrAddr),
        .Inst       (Inst),
        .Iaddr      (Iaddr),
        .dPC4       (dPC4),
        .dInst      (dInst),
        .dValid     (dValid)
`ifdef IF_PERF_CNT_EN
        ,
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
`endif
    );

    // instruction memory model: word at address a reads as A000_0000 + a
    assign Inst = 32'hA000_0000 + Iaddr;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] ia, input logic [31:0] pc4,
                          input logic [31:0] ins, input logic v);
        chk({tag, "_iaddr"}, Iaddr, ia);
        chk({tag, "_dpc4"}, dPC4, pc4);
        chk({tag, "_dinst"}, dInst, ins);
        chk({tag, "_dvalid"}, {31'd0, dValid}, {31'd0, v});
    endtask

    initial begin
        Clrn = 1'b0; STALL = 1'b1; Condep = 1'b1; Pcsrc = 2'b00; jr = 1'b0;
        BranchAddr = 32'd0; JumpAddr = 32'd0; JrAddr = 32'd0;
        #2;
        chk_if("reset", 32'h0, 32'h0, NOP, 1'b0);
        #10 Clrn = 1'b1;

        tick();  // BOOT edge
        chk_if("boot", 32'h0, 32'h0, NOP, 1'b0);
        tick();
        chk_if("run0", 32'h4, 32'h4, 32'hA000_0000, 1'b1);
        tick();
        chk_if("run1", 32'h8, 32'h8, 32'hA000_0004, 1'b1);
        tick();
        tick();
        chk_if("run3", 32'h10, 32'h10, 32'hA000_000C, 1'b1);

        STALL = 1'b0;
        tick();
        chk_if("stall1", 32'h10, 32'h10, 32'hA000_000C, 1'b1);
        tick();
        chk_if("stall2", 32'h10, 32'h10, 32'hA000_000C, 1'b1);
        STALL = 1'b1;
        tick();
        chk_if("resume", 32'h14, 32'h14, 32'hA000_0010, 1'b1);
        tick();
        tick();
        tick();
        chk("at20", Iaddr, 32'h20);

        // flush with simultaneous stall, misaligned branch target
        Pcsrc = 2'b10; BranchAddr = 32'h103; Condep = 1'b0; STALL = 1'b0;
        tick();
        chk_if("flush", 32'h100, 32'h0, NOP, 1'b0);
        Pcsrc = 2'b00; Condep = 1'b1; STALL = 1'b1;
        tick();
        chk_if("postflush", 32'h104, 32'h104, 32'hA000_0100, 1'b1);

        // jump with delay slot to reach 0x30
        Pcsrc = 2'b11; JumpAddr = 32'h30;
        tick();
        chk_if("jump", 32'h30, 32'h108, 32'hA000_0104, 1'b1);

        // jr beats Pcsrc=11
        jr = 1'b1; JrAddr = 32'h200; JumpAddr = 32'h400;
        tick();
        chk_if("jr", 32'h200, 32'h34, 32'hA000_0030, 1'b1);

        // masked jr target, then wrap of PC+4
        JrAddr = 32'hFFFF_FFFF; Pcsrc = 2'b00;
        tick();
        chk("jr_mask", Iaddr, 32'hFFFF_FFFC);
        jr = 1'b0;
        tick();
        chk_if("wrap", 32'h0, 32'h0, 32'h9FFF_FFFC, 1'b1);

        STALL = 1'b0;
        tick();
        chk("stall3", Iaddr, 32'h0);
        STALL = 1'b1; Condep = 1'b0;
        tick();
        chk_if("flush2", 32'h4, 32'h0, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("stallcnt", StallCnt, 32'd3);
        chk("flushcnt", FlushCnt, 32'd2);
`endif

        // async reset in the middle of a stall cycle
        Condep = 1'b1; STALL = 1'b0;
        tick();
        #2 Clrn = 1'b0;
        #1;
        chk_if("async_rst", 32'h0, 32'h0, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("stallcnt_rst", StallCnt, 32'd0);
        chk("flushcnt_rst", FlushCnt, 32'd0);
`endif
        // controls must be ignored during BOOT
        Condep = 1'b0; STALL = 1'b1; Pcsrc = 2'b11; JumpAddr = 32'h500;
        #2 Clrn = 1'b1;
        tick();
        chk_if("boot2", 32'h0, 32'h0, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("flushcnt_boot", FlushCnt, 32'd0);
`endif
        Condep = 1'b1; Pcsrc = 2'b00;
        tick();
        chk_if("run_after", 32'h4, 32'h4, 32'hA000_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
